array_cmd_seq: RTL



---
 rtl/array_cmd_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/array_cmd_seq.sv
// array_cmd_seq: command initiator for the CIM array controller.
// Accepts host commands (valid/ready), drives one array op per beat,
// waits RES_LAT cycles, captures the adder-tree result and returns it
// on a valid/ready response channel. Ops: 00 MAC, 01 write, 10 read
// burst across columns, 11 NOP.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready host command handshake
//   cmd_op/bank/col/len/wdata/act  command fields
//   op_code, addr_bank, addr_col, data_bank, data_in  array request bus
//   arr_result      adder-tree result from the array
//   rsp_valid/ready response handshake
//   rsp_data, rsp_last  captured result, final-beat flag
//   perf_ops, perf_stall  activity counters (ARRAY_CMD_PERF_EN only)
//
// Optional feature macro: ARRAY_CMD_PERF_EN adds saturating counters
// perf_ops (ISSUE cycles) and perf_stall (response back-pressure cycles).

module array_cmd_seq #(
   parameter int RES_W   = 20,
   parameter int RES_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_bank,
   input  logic [2:0]       cmd_col,
   input  logic [2:0]       cmd_len,
   input  logic [15:0]      cmd_wdata,
   input  logic [15:0]      cmd_act,
   output logic [1:0]       op_code,
   output logic [3:0]       addr_bank,
   output logic [2:0]       addr_col,
   output logic [15:0]      data_bank,
   output logic [15:0]      data_in,
   input  logic [RES_W-1:0] arr_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [RES_W-1:0] rsp_data,
   output logic             rsp_last
`ifdef ARRAY_CMD_PERF_EN
   ,
   output logic [15:0]      perf_ops,
   output logic [15:0]      perf_stall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_MAC = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] LAT_INIT = 4'(RES_LAT);

   state_t           state_q, state_d;
   logic [1:0]       op_q,    op_d;
   logic [3:0]       bank_q,  bank_d;
   logic [2:0]       col_q,   col_d;
   logic [2:0]       beat_q,  beat_d;
   logic [15:0]      wdata_q, wdata_d;
   logic [15:0]      act_q,   act_d;
   logic [3:0]       lat_q,   lat_d;
   logic [RES_W-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         bank_q  <= '0;
         col_q   <= '0;
         beat_q  <= '0;
         wdata_q <= '0;
         act_q   <= '0;
         lat_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         bank_q  <= bank_d;
         col_q   <= col_d;
         beat_q  <= beat_d;
         wdata_q <= wdata_d;
         act_q   <= act_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      bank_d    = bank_q;
      col_d     = col_q;
      beat_d    = beat_q;
      wdata_d   = wdata_q;
      act_d     = act_q;
      lat_d     = lat_q;
      rdata_d   = rdata_q;
      cmd_ready = 1'b0;
      op_code   = OP_NOP;
      addr_bank = '0;
      addr_col  = '0;
      data_bank = '0;
      data_in   = '0;
      rsp_valid = 1'b0;
      rsp_last  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Registers are held in reset while rst is high, so
            // only the ready output needs explicit gating.
            cmd_ready = ~rst;
            if (cmd_valid) begin
               op_d    = cmd_op;
               bank_d  = cmd_bank;
               col_d   = cmd_col;
               wdata_d = cmd_wdata;
               act_d   = cmd_act;
               beat_d  = (cmd_op == OP_RD) ? cmd_len : 3'd0;
               if (cmd_op == OP_NOP) begin
                  rdata_d = '0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            op_code   = op_q;
            addr_bank = bank_q;
            addr_col  = col_q;
            data_bank = wdata_q;
            data_in   = act_q;
            lat_d     = LAT_INIT;
            state_d   = S_WAIT;
         end

         S_WAIT: begin
            lat_d = lat_q - 4'd1;
            // lat_q==1 marks the RES_LAT-th cycle after ISSUE.
            if (lat_q == 4'd1) begin
               rdata_d = (op_q == OP_WR) ? '0 : arr_result;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = (beat_q == 3'd0);
            if (rsp_ready) begin
               if (beat_q == 3'd0) begin
                  state_d = S_IDLE;
               end else begin
                  beat_d  = beat_q - 3'd1;
                  col_d   = col_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rsp_data = rdata_q;

`ifdef ARRAY_CMD_PERF_EN
   logic [15:0] ops_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_q   <= '0;
         stall_q <= '0;
      end else begin
         if (state_q == S_ISSUE && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
         end
         if (rsp_valid && !rsp_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   assign perf_ops   = ops_q;
   assign perf_stall = stall_q;
`endif

endmodule
